dma_channel_arbiter: RTL and testbench



---
 rtl/dma_channel_arbiter.sv | 122 ++++++++++++
 tb/tb_dma_channel_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter: 4-channel DMA request arbiter with a HRQ/HLDA handshake.
// States: IDLE -> REQ -> GRANT -> RELEASE -> IDLE.
// The REQ state can also go straight to RELEASE when the latched request is withdrawn.
// Optional rotating priority is built only when DMA_ROTATE_PRIORITY_EN is defined.
// Without that macro, ROTATE is ignored and PRI_TOP is tied to 0.
module dma_channel_arbiter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic       DREQ_SENSE_LOW,
  input  logic       DACK_SENSE_HIGH,
  input  logic [3:0] MASK,
  input  logic       CTRL_DISABLE,
  input  logic       ROTATE,
  input  logic       HLDA,
  input  logic       XFER_DONE,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic [1:0] CH_SEL,
  output logic       ACTIVE_CYCLE,
  output logic       IDLE_CYCLE,
  output logic [1:0] PRI_TOP
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GRANT, S_REL} state_t;

  state_t     state_q;
  logic       hrq_q, active_q, idle_q;
  logic [1:0] ch_sel_q;
  logic [3:0] dack_sel_q;   // one-hot, active-high; polarity applied at the port
  logic [1:0] pri_top;
  logic [3:0] valid;
  logic [1:0] win, idx;
  logic       found;

  assign valid = (DREQ ^ {4{DREQ_SENSE_LOW}}) & ~MASK;

  // Round-robin scan starting at the current top-priority channel
  always_comb begin
    win   = pri_top;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = pri_top + 2'(i);
      if (!found && valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

`ifdef DMA_ROTATE_PRIORITY_EN
  logic [1:0] pri_top_q;
  // Top priority moves past the channel just serviced; fixed mode pins it at 0
  always_ff @(posedge CLK) begin
    if (RESET || !ROTATE)
      pri_top_q <= 2'd0;
    else if (state_q == S_GRANT && XFER_DONE)
      pri_top_q <= ch_sel_q + 2'd1;
  end
  assign pri_top = pri_top_q;
`else
  logic unused_rotate;
  assign unused_rotate = ROTATE;
  assign pri_top = 2'd0;
`endif

  // Arbitration FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      hrq_q      <= 1'b0;
      active_q   <= 1'b0;
      idle_q     <= 1'b1;
      ch_sel_q   <= 2'd0;
      dack_sel_q <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!CTRL_DISABLE && found) begin
            state_q  <= S_REQ;
            ch_sel_q <= win;
            hrq_q    <= 1'b1;
            idle_q   <= 1'b0;
          end
        end
        S_REQ: begin
          if (HLDA) begin
            state_q    <= S_GRANT;
            active_q   <= 1'b1;
            dack_sel_q <= 4'b0001 << ch_sel_q;
          end else if (!valid[ch_sel_q]) begin
            // requester withdrew before the bus was handed over
            state_q <= S_REL;
            hrq_q   <= 1'b0;
          end
        end
        S_GRANT: begin
          // no preemption: only completion or loss of HLDA ends the grant
          if (XFER_DONE || !HLDA) begin
            state_q    <= S_REL;
            hrq_q      <= 1'b0;
            active_q   <= 1'b0;
            dack_sel_q <= 4'd0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign HRQ          = hrq_q;
  assign DACK         = DACK_SENSE_HIGH ? dack_sel_q : ~dack_sel_q;
  assign CH_SEL       = ch_sel_q;
  assign ACTIVE_CYCLE = active_q;
  assign IDLE_CYCLE   = idle_q;
  assign PRI_TOP      = pri_top;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter; rotation expectations follow DMA_ROTATE_PRIORITY_EN.
module tb_dma_channel_arbiter;
  logic       CLK = 1'b0, RESET, DREQ_SENSE_LOW, DACK_SENSE_HIGH, CTRL_DISABLE, ROTATE, HLDA, XFER_DONE;
  logic [3:0] DREQ, MASK, DACK;
  logic       HRQ, ACTIVE_CYCLE, IDLE_CYCLE;
  logic [1:0] CH_SEL, PRI_TOP;
  int n_chk = 0, n_fail = 0;

`ifdef DMA_ROTATE_PRIORITY_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  dma_channel_arbiter dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .DREQ_SENSE_LOW(DREQ_SENSE_LOW),
    .DACK_SENSE_HIGH(DACK_SENSE_HIGH), .MASK(MASK), .CTRL_DISABLE(CTRL_DISABLE),
    .ROTATE(ROTATE), .HLDA(HLDA), .XFER_DONE(XFER_DONE), .HRQ(HRQ), .DACK(DACK),
    .CH_SEL(CH_SEL), .ACTIVE_CYCLE(ACTIVE_CYCLE), .IDLE_CYCLE(IDLE_CYCLE), .PRI_TOP(PRI_TOP)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  // finish a GRANT with XFER_DONE, then drop everything and return to IDLE
  task automatic complete_and_idle;
    XFER_DONE = 1'b1; tick;
    XFER_DONE = 1'b0; HLDA = 1'b0; DREQ = 4'd0; tick;
  endtask

  task automatic test_reset;
    RESET = 1'b1; tick; tick; RESET = 1'b0;
    n_chk++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL rst_hrq got=%b exp=0", HRQ); end
    n_chk++; if (DACK !== 4'b0000) begin n_fail++; $display("FAIL rst_dack got=%b exp=0000", DACK); end
    n_chk++; if (CH_SEL !== 2'd0) begin n_fail++; $display("FAIL rst_chsel got=%0d exp=0", CH_SEL); end
    n_chk++; if (PRI_TOP !== 2'd0) begin n_fail++; $display("FAIL rst_pri got=%0d exp=0", PRI_TOP); end
    n_chk++; if (ACTIVE_CYCLE !== 1'b0) begin n_fail++; $display("FAIL rst_active got=%b exp=0", ACTIVE_CYCLE); end
    n_chk++; if (IDLE_CYCLE !== 1'b1) begin n_fail++; $display("FAIL rst_idle got=%b exp=1", IDLE_CYCLE); end
    DACK_SENSE_HIGH = 1'b0; #1;
    n_chk++; if (DACK !== 4'b1111) begin n_fail++; $display("FAIL rst_dack_low got=%b exp=1111", DACK); end
    DACK_SENSE_HIGH = 1'b1; #1;
  endtask

  task automatic test_fixed_priority;
    ROTATE = 1'b0; DREQ = 4'b1010; tick;
    n_chk++; if (HRQ !== 1'b1) begin n_fail++; $display("FAIL fix_hrq got=%b exp=1", HRQ); end
    n_chk++; if (CH_SEL !== 2'd1) begin n_fail++; $display("FAIL fix_chsel_req got=%0d exp=1", CH_SEL); end
    n_chk++; if (DACK !== 4'b0000) begin n_fail++; $display("FAIL fix_dack_req got=%b exp=0000", DACK); end
    HLDA = 1'b1; tick;
    n_chk++; if (DACK !== 4'b0010) begin n_fail++; $display("FAIL fix_dack got=%b exp=0010", DACK); end
    n_chk++; if (ACTIVE_CYCLE !== 1'b1) begin n_fail++; $display("FAIL fix_active got=%b exp=1", ACTIVE_CYCLE); end
    // disturb inputs during GRANT: no preemption expected
    MASK = 4'b0010; DREQ = 4'b0001; CTRL_DISABLE = 1'b1; tick;
    n_chk++; if (CH_SEL !== 2'd1) begin n_fail++; $display("FAIL fix_nopre_ch got=%0d exp=1", CH_SEL); end
    n_chk++; if (DACK !== 4'b0010) begin n_fail++; $display("FAIL fix_nopre_dack got=%b exp=0010", DACK); end
    MASK = 4'd0; CTRL_DISABLE = 1'b0; DREQ = 4'b1010;
    XFER_DONE = 1'b1; tick;
    n_chk++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL fix_rel_hrq got=%b exp=0", HRQ); end
    n_chk++; if (DACK !== 4'b0000) begin n_fail++; $display("FAIL fix_rel_dack got=%b exp=0000", DACK); end
    n_chk++; if (IDLE_CYCLE !== 1'b0) begin n_fail++; $display("FAIL fix_rel_idle got=%b exp=0", IDLE_CYCLE); end
    XFER_DONE = 1'b0; HLDA = 1'b0; DREQ = 4'b1000; tick;
    n_chk++; if (IDLE_CYCLE !== 1'b1) begin n_fail++; $display("FAIL fix_idle got=%b exp=1", IDLE_CYCLE); end
    tick;
    n_chk++; if (CH_SEL !== 2'd3) begin n_fail++; $display("FAIL fix_ch3 got=%0d exp=3", CH_SEL); end
    HLDA = 1'b1; tick;
    n_chk++; if (DACK !== 4'b1000) begin n_fail++; $display("FAIL fix_dack3 got=%b exp=1000", DACK); end
    complete_and_idle;
  endtask

  task automatic test_rotation;
    logic [1:0] exp_ch, exp_pri;
    ROTATE = 1'b1; DREQ = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp_ch  = ROT ? 2'(k) : 2'd0;
      exp_pri = ROT ? 2'(k + 1) : 2'd0;
      tick;
      n_chk++; if (CH_SEL !== exp_ch) begin n_fail++; $display("FAIL rot_ch[%0d] got=%0d exp=%0d", k, CH_SEL, exp_ch); end
      HLDA = 1'b1; tick;
      n_chk++; if (DACK !== (4'b0001 << exp_ch)) begin n_fail++; $display("FAIL rot_dack[%0d] got=%b", k, DACK); end
      XFER_DONE = 1'b1; tick;
      n_chk++; if (PRI_TOP !== exp_pri) begin n_fail++; $display("FAIL rot_pri[%0d] got=%0d exp=%0d", k, PRI_TOP, exp_pri); end
      XFER_DONE = 1'b0; HLDA = 1'b0; tick;
    end
    DREQ = 4'd0; tick; tick;
  endtask

  task automatic test_mask_polarity;
    ROTATE = 1'b0; DREQ_SENSE_LOW = 1'b1; DREQ = 4'b1011; MASK = 4'b0100; tick; tick;
    n_chk++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL pol_masked_hrq got=%b exp=0", HRQ); end
    n_chk++; if (IDLE_CYCLE !== 1'b1) begin n_fail++; $display("FAIL pol_masked_idle got=%b exp=1", IDLE_CYCLE); end
    MASK = 4'd0; tick;
    n_chk++; if (CH_SEL !== 2'd2) begin n_fail++; $display("FAIL pol_ch got=%0d exp=2", CH_SEL); end
    DACK_SENSE_HIGH = 1'b0; HLDA = 1'b1; tick;
    n_chk++; if (DACK !== 4'b1011) begin n_fail++; $display("FAIL pol_dack got=%b exp=1011", DACK); end
    DREQ_SENSE_LOW = 1'b0; XFER_DONE = 1'b1; DREQ = 4'd0; tick;
    n_chk++; if (DACK !== 4'b1111) begin n_fail++; $display("FAIL pol_rel_dack got=%b exp=1111", DACK); end
    XFER_DONE = 1'b0; HLDA = 1'b0; DACK_SENSE_HIGH = 1'b1; tick;
  endtask

  task automatic test_ctrl_disable;
    CTRL_DISABLE = 1'b1; DREQ = 4'b0001; tick; tick;
    n_chk++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL dis_hrq got=%b exp=0", HRQ); end
    DREQ = 4'd0; CTRL_DISABLE = 1'b0; tick;
  endtask

  task automatic test_cancel;
    ROTATE = 1'b1; DREQ = 4'b0010; tick;
    n_chk++; if (CH_SEL !== 2'd1) begin n_fail++; $display("FAIL can_ch got=%0d exp=1", CH_SEL); end
    DREQ = 4'd0; tick;
    n_chk++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL can_hrq got=%b exp=0", HRQ); end
    n_chk++; if (DACK !== 4'b0000) begin n_fail++; $display("FAIL can_dack got=%b exp=0000", DACK); end
    n_chk++; if (IDLE_CYCLE !== 1'b0) begin n_fail++; $display("FAIL can_rel_idle got=%b exp=0", IDLE_CYCLE); end
    n_chk++; if (PRI_TOP !== 2'd0) begin n_fail++; $display("FAIL can_pri got=%0d exp=0", PRI_TOP); end
    tick;
    n_chk++; if (IDLE_CYCLE !== 1'b1) begin n_fail++; $display("FAIL can_idle got=%b exp=1", IDLE_CYCLE); end
  endtask

  task automatic test_hlda_loss;
    DREQ = 4'b0100; tick;
    HLDA = 1'b1; tick;
    n_chk++; if (DACK !== 4'b0100) begin n_fail++; $display("FAIL hl_dack got=%b exp=0100", DACK); end
    HLDA = 1'b0; tick;
    n_chk++; if (HRQ !== 1'b0 || DACK !== 4'b0000) begin n_fail++; $display("FAIL hl_rel got=%b/%b exp=0/0000", HRQ, DACK); end
    n_chk++; if (PRI_TOP !== 2'd0) begin n_fail++; $display("FAIL hl_pri got=%0d exp=0", PRI_TOP); end
    tick; tick;
    n_chk++; if (CH_SEL !== 2'd2) begin n_fail++; $display("FAIL hl_ch2 got=%0d exp=2", CH_SEL); end
    HLDA = 1'b1; tick;
    XFER_DONE = 1'b1; HLDA = 1'b0; tick;
    n_chk++; if (PRI_TOP !== (ROT ? 2'd3 : 2'd0)) begin n_fail++; $display("FAIL hl_simul_pri got=%0d exp=%0d", PRI_TOP, ROT ? 3 : 0); end
    n_chk++; if (ACTIVE_CYCLE !== 1'b0) begin n_fail++; $display("FAIL hl_simul_active got=%b exp=0", ACTIVE_CYCLE); end
    XFER_DONE = 1'b0; DREQ = 4'd0; tick;
  endtask

  task automatic test_reset_mid_grant;
    DREQ = 4'b1000; tick;
    HLDA = 1'b1; tick;
    n_chk++; if (ACTIVE_CYCLE !== 1'b1) begin n_fail++; $display("FAIL rg_active got=%b exp=1", ACTIVE_CYCLE); end
    RESET = 1'b1; tick;
    n_chk++; if (HRQ !== 1'b0) begin n_fail++; $display("FAIL rg_hrq got=%b exp=0", HRQ); end
    n_chk++; if (DACK !== 4'b0000) begin n_fail++; $display("FAIL rg_dack got=%b exp=0000", DACK); end
    n_chk++; if (IDLE_CYCLE !== 1'b1) begin n_fail++; $display("FAIL rg_idle got=%b exp=1", IDLE_CYCLE); end
    n_chk++; if (PRI_TOP !== 2'd0) begin n_fail++; $display("FAIL rg_pri got=%0d exp=0", PRI_TOP); end
    n_chk++; if (CH_SEL !== 2'd0) begin n_fail++; $display("FAIL rg_ch got=%0d exp=0", CH_SEL); end
    RESET = 1'b0; HLDA = 1'b0; DREQ = 4'd0; tick;
  endtask

  initial begin
    RESET = 1'b1; DREQ = 4'd0; DREQ_SENSE_LOW = 1'b0; DACK_SENSE_HIGH = 1'b1; MASK = 4'd0;
    CTRL_DISABLE = 1'b0; ROTATE = 1'b0; HLDA = 1'b0; XFER_DONE = 1'b0;
    test_reset;
    test_fixed_priority;
    test_rotation;
    test_mask_polarity;
    test_ctrl_disable;
    test_cancel;
    test_hlda_loss;
    test_reset_mid_grant;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
